// File: rtl/cdc_xfer_arb_if.sv
// Bundle between the requesters/remote side and the arbiter that shares one
// toggle-based CDC channel.
interface cdc_xfer_arb_if #(
  parameter int N  = 4,
  parameter int DW = 8
);
  localparam int ID_W = $clog2(N);

  logic [N-1:0]    req;
  logic [N*DW-1:0] data;
  logic [N-1:0]    done;
  logic [N-1:0]    err;
  logic            busy;
  logic            xfer_tgl;
  logic [ID_W-1:0] xfer_id;
  logic [DW-1:0]   xfer_data;
  logic            ack_tgl;

  modport master (
    output req, data, ack_tgl,
    input  done, err, busy, xfer_tgl, xfer_id, xfer_data
  );

  modport slave (
    input  req, data, ack_tgl,
    output done, err, busy, xfer_tgl, xfer_id, xfer_data
  );
endinterface

// File: rtl/cdc_xfer_arb.sv
// Round-robin arbiter that sequences N requesters through one toggle-handshake
// CDC channel: grant, flip xfer_tgl, wait for the synchronised echo.
module cdc_xfer_arb #(
  parameter int N       = 4,
  parameter int DW      = 8,
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 8
) (
  input logic           clk,
  input logic           rstn,
  cdc_xfer_arb_if.slave bus
);
  localparam int ID_W = $clog2(N);
  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_DRAIN} state_t;

  state_t          state, state_nxt;
  logic            ack_meta, ack_s;
  logic [ID_W-1:0] rr_ptr;
  logic [TO_W-1:0] timer;
  logic            tgl;
  logic [ID_W-1:0] id_r;
  logic [DW-1:0]   data_r;
  logic [N-1:0]    done_r, err_r;
  logic            grant_vld;
  logic [ID_W-1:0] grant_idx;
  logic            ack_match, to_hit;
  logic [DW-1:0]   data_arr [N];

  function automatic logic [TO_W-1:0] sat_inc(input logic [TO_W-1:0] t);
    return (&t) ? t : t + 1'b1;
  endfunction

  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] i);
    return (i == ID_W'(N - 1)) ? '0 : i + 1'b1;
  endfunction

  function automatic logic [N-1:0] onehot(input logic [ID_W-1:0] i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign data_arr[g] = bus.data[g*DW +: DW];
  end

  // Search upward from the pointer with wrap; the first set bit wins.
  always_comb begin : p_grant
    int idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!grant_vld && bus.req[ID_W'(idx)]) begin
        grant_vld = 1'b1;
        grant_idx = ID_W'(idx);
      end
    end
  end

  assign ack_match = (ack_s == tgl);
  assign to_hit    = TO_EN && (timer == TO_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // An ack arriving on the timeout cycle takes precedence over the error.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant_vld) state_nxt = S_WAIT;
      S_WAIT: begin
        if (ack_match)   state_nxt = S_DONE;
        else if (to_hit) state_nxt = S_DRAIN;
      end
      S_DONE:  state_nxt = S_IDLE;
      S_DRAIN: if (ack_match) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ack_meta <= 1'b0;
      ack_s    <= 1'b0;
      rr_ptr   <= '0;
      timer    <= '0;
      tgl      <= 1'b0;
      id_r     <= '0;
      data_r   <= '0;
      done_r   <= '0;
      err_r    <= '0;
    end else begin
      ack_meta <= bus.ack_tgl;
      ack_s    <= ack_meta;
      done_r   <= '0;
      err_r    <= '0;
      case (state)
        S_IDLE: if (grant_vld) begin
          id_r   <= grant_idx;
          data_r <= data_arr[grant_idx];
          tgl    <= ~tgl;
          timer  <= '0;
          rr_ptr <= wrap_inc(grant_idx);
        end
        S_WAIT: begin
          timer <= sat_inc(timer);
          if (state_nxt == S_DONE)       done_r <= onehot(id_r);
          else if (state_nxt == S_DRAIN) err_r  <= onehot(id_r);
        end
        default: ;
      endcase
    end
  end

  assign bus.done      = done_r;
  assign bus.err       = err_r;
  assign bus.busy      = (state != S_IDLE);
  assign bus.xfer_tgl  = tgl;
  assign bus.xfer_id   = id_r;
  assign bus.xfer_data = data_r;
endmodule

// File: tb/tb_cdc_xfer_arb.sv
// Scoreboard bench for cdc_xfer_arb: directed transfers push expected done/err
// responses; a negedge monitor pops and compares them as they appear.
module tb_cdc_xfer_arb;
  localparam int N  = 4;
  localparam int DW = 8;

  typedef struct {
    logic       is_err;
    logic [1:0] id;
    logic [7:0] d;
    logic       tgl;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  logic lb;
  logic ack_man;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  exp_t exp_q [$];

  cdc_xfer_arb_if #(.N(N), .DW(DW)) bus ();

  cdc_xfer_arb #(.N(N), .DW(DW), .TIMEOUT(8), .TO_W(8)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  assign bus.ack_tgl = lb ? bus.xfer_tgl : ack_man;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push(input logic is_err, input logic [1:0] id, input logic [7:0] d,
                      input logic t, input int c);
    exp_t e;
    e.is_err = is_err; e.id = id; e.d = d; e.tgl = t; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic drop_at(input int n, input logic [3:0] m);
    wait_cyc(n - 1);
    @(posedge clk);
    #1;
    bus.req = bus.req & ~m;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn    = 1'b0;
    bus.req = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic single_xfer();
    int c0;
    c0 = cyc;
    chk("single_idle_tgl", bus.xfer_tgl, 0);
    chk("single_idle_busy", bus.busy, 0);
    bus.data[0 +: DW] = 8'hA5;
    bus.req = 4'b0001;
    push(1'b0, 2'd0, 8'hA5, 1'b1, c0 + 4);
    wait_cyc(c0 + 1);
    chk("single_tgl", bus.xfer_tgl, 1);
    chk("single_busy", bus.busy, 1);
    chk("single_id", bus.xfer_id, 0);
    chk("single_data", bus.xfer_data, 8'hA5);
    drop_at(c0 + 5, 4'b0001);
    chk("single_busy_end", bus.busy, 0);
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (rstn === 1'b1 && (bus.done != '0 || bus.err != '0)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", {24'd0, bus.done, bus.err}, 0);
      end else begin
        exp_t e;
        logic [3:0] oh;
        e  = exp_q.pop_front();
        oh = 4'b0001 << e.id;
        chk("resp_done", bus.done, e.is_err ? 4'b0000 : oh);
        chk("resp_err", bus.err, e.is_err ? oh : 4'b0000);
        chk("resp_id", bus.xfer_id, e.id);
        chk("resp_data", bus.xfer_data, e.d);
        chk("resp_tgl", bus.xfer_tgl, e.tgl);
        chk("resp_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int c1;
    logic [7:0] dv [4];
    rstn = 1'b0; lb = 1'b1; ack_man = 1'b0;
    bus.req = '0; bus.data = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_tgl", bus.xfer_tgl, 0);
    chk("rst_id", bus.xfer_id, 0);
    chk("rst_data", bus.xfer_data, 0);
    rstn = 1'b1;
    @(negedge clk);

    single_xfer();

    // Data stability: requester 1 after pointer moved to 1, tgl 1 -> 0
    c0 = cyc;
    bus.data[1*DW +: DW] = 8'h5A;
    bus.req = 4'b0010;
    push(1'b0, 2'd1, 8'h5A, 1'b0, c0 + 4);
    for (int k = 1; k <= 4; k++) begin
      wait_cyc(c0 + k);
      chk("stable_data", bus.xfer_data, 8'h5A);
      bus.data[1*DW +: DW] = 8'h11 * k[7:0] + 8'h03;
      bus.data[0 +: DW]    = ~bus.data[0 +: DW];
    end
    drop_at(c0 + 5, 4'b0010);
    chk("stable_data_hold", bus.xfer_data, 8'h5A);
    chk("stable_id_hold", bus.xfer_id, 1);

    // Reset mid-WAIT with xfer_tgl = 1
    c0 = cyc;
    bus.data[2*DW +: DW] = 8'h5C;
    bus.req = 4'b0100;
    wait_cyc(c0 + 2);
    chk("midrst_busy_pre", bus.busy, 1);
    chk("midrst_tgl_pre", bus.xfer_tgl, 1);
    #2 rstn = 1'b0;
    #1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_tgl", bus.xfer_tgl, 0);
    chk("midrst_id", bus.xfer_id, 0);
    chk("midrst_data", bus.xfer_data, 0);
    chk("midrst_done_err", {bus.done, bus.err}, 0);
    @(negedge clk);
    bus.req = '0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    single_xfer();

    // Round-robin from a fresh pointer
    do_reset();
    dv[0] = 8'h11; dv[1] = 8'h22; dv[2] = 8'h33; dv[3] = 8'h44;
    for (int i = 0; i < 4; i++) bus.data[i*DW +: DW] = dv[i];
    c0 = cyc;
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++)
      push(1'b0, 2'(k % 4), dv[k % 4], (k % 2 == 0), c0 + 4 + 5 * k);
    drop_at(c0 + 25, 4'b1111);
    chk("rr_busy_end", bus.busy, 0);
    @(negedge clk);
    chk("rr_no_extra", bus.busy, 0);

    // Timeout with ack held at 0, then late ack drains
    lb = 1'b0; ack_man = 1'b0;
    do_reset();
    c0 = cyc;
    bus.data[2*DW +: DW] = 8'h3C;
    bus.req = 4'b0100;
    push(1'b1, 2'd2, 8'h3C, 1'b1, c0 + 9);
    drop_at(c0 + 10, 4'b0100);
    wait_cyc(c0 + 14);
    chk("drain_busy", bus.busy, 1);
    ack_man = 1'b1;
    wait_cyc(c0 + 16);
    chk("drain_busy_late", bus.busy, 1);
    wait_cyc(c0 + 17);
    chk("drain_exit", bus.busy, 0);
    lb = 1'b1;
    c1 = cyc;
    bus.data[0 +: DW] = 8'h96;
    bus.req = 4'b0001;
    push(1'b0, 2'd0, 8'h96, 1'b0, c1 + 4);
    wait_cyc(c1 + 1);
    chk("post_to_tgl", bus.xfer_tgl, 0);
    drop_at(c1 + 5, 4'b0001);

    // Ack lands on the timeout boundary cycle: done wins
    ack_man = 1'b0; lb = 1'b0;
    c0 = cyc;
    bus.data[3*DW +: DW] = 8'hE7;
    bus.req = 4'b1000;
    push(1'b0, 2'd3, 8'hE7, 1'b1, c0 + 9);
    wait_cyc(c0 + 6);
    ack_man = 1'b1;
    drop_at(c0 + 10, 4'b1000);
    chk("bound_busy_end", bus.busy, 0);
    repeat (4) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
